// File: rtl/input_mems_pingpong.sv
// input_mems_pingpong
//   Double-buffered matrix input memory between the AXI-Stream input and the
//   MAC array. Two load slots each hold one A (M x K) and one B (K x N) set,
//   so the next set can stream in while compute reads the current one.
//   A set loaded with newA=0 carries only B and reuses the most recent A bank.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   AXIS_TDATA/TVALID   stream data / valid
//   AXIS_TUSER          [0]=newA, [K_BITS:1]=K, sampled on the first word of a set
//   AXIS_TREADY         stream ready
//   matrices_loaded     read slot holds a complete set
//   compute_finished    one-cycle pulse releasing the read slot
//   K                   inner dimension of the read slot
//   A_read_addr/A_data  A read port, row-major M*K, 1-cycle latency
//   B_read_addr/B_data  B read port, 1-cycle latency
//   k_err               (only with INPUT_MEMS_KCHECK_EN) sticky flag for a
//                       first word whose K is 0 or above MAXK
//
// Build option: define INPUT_MEMS_KCHECK_EN to enable K range checking.
//
// Load FSM
//   state  | meaning
//   IDLE   | waiting for the first word of a set; TUSER sampled here
//   LOAD_A | streaming A words into A bank wr_slot
//   LOAD_B | streaming B words into B bank wr_slot; last word marks slot full

module input_mems_pingpong #(
    parameter int INW  = 12,
    parameter int M    = 7,
    parameter int N    = 9,
    parameter int MAXK = 8,
    localparam int K_BITS      = $clog2(MAXK + 1),
    localparam int A_ADDR_BITS = $clog2(M * MAXK),
    localparam int B_ADDR_BITS = $clog2(MAXK * N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INW-1:0]         AXIS_TDATA,
    input  logic                   AXIS_TVALID,
    input  logic [K_BITS:0]        AXIS_TUSER,
    output logic                   AXIS_TREADY,
    output logic                   matrices_loaded,
    input  logic                   compute_finished,
    output logic [K_BITS-1:0]      K,
    input  logic [A_ADDR_BITS-1:0] A_read_addr,
    output logic signed [INW-1:0]  A_data,
    input  logic [B_ADDR_BITS-1:0] B_read_addr,
    output logic signed [INW-1:0]  B_data
`ifdef INPUT_MEMS_KCHECK_EN
    ,
    output logic                   k_err
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B} state_t;

    state_t                 state;
    logic [1:0]             full;
    logic [K_BITS-1:0]      k_slot [2];
    logic [1:0]             a_ptr;      // A bank used by each slot
    logic                   last_a;     // A bank of the most recent newA set
    logic                   wr_slot;
    logic                   rd_slot;
    logic [A_ADDR_BITS-1:0] a_addr;
    logic [B_ADDR_BITS-1:0] b_addr;

    logic signed [INW-1:0]  a_mem [2][2**A_ADDR_BITS];
    logic signed [INW-1:0]  b_mem [2][2**B_ADDR_BITS];

    logic                   user_new_a;
    logic [K_BITS-1:0]      user_k;
    logic                   k_ok;
    logic                   a_block;
    logic                   tready_int;
    logic                   accept;
    logic [K_BITS-1:0]      k_cur;
    logic                   a_last;
    logic                   b_last;
    logic                   a_we;
    logic                   b_we;

    assign user_new_a = AXIS_TUSER[0];
    assign user_k     = AXIS_TUSER[K_BITS:1];

`ifdef INPUT_MEMS_KCHECK_EN
    assign k_ok = (user_k != '0) && (int'(user_k) <= MAXK);
`else
    assign k_ok = 1'b1;
`endif

    // A new A set may not overwrite the A bank that the other, still-full
    // slot is referencing; hold off the stream until that slot is released.
    assign a_block    = user_new_a && full[~wr_slot] && (a_ptr[~wr_slot] == wr_slot);
    assign tready_int = (state == IDLE) ? (!full[wr_slot] && !a_block) : 1'b1;
    assign AXIS_TREADY = tready_int && !reset;
    assign accept     = AXIS_TVALID && AXIS_TREADY;

    assign k_cur  = k_slot[wr_slot];
    assign a_last = (a_addr == A_ADDR_BITS'(M * int'(k_cur) - 1));
    assign b_last = (b_addr == B_ADDR_BITS'(N * int'(k_cur) - 1));

    // Addresses sit at 0 while IDLE, so the first word lands at address 0.
    assign a_we = accept && (((state == IDLE) && user_new_a && k_ok) || (state == LOAD_A));
    assign b_we = accept && (((state == IDLE) && !user_new_a && k_ok) || (state == LOAD_B));

    assign matrices_loaded = full[rd_slot];
    assign K               = k_slot[rd_slot];

    // Storage and read ports; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (a_we)
            a_mem[wr_slot][a_addr] <= AXIS_TDATA;
        if (b_we)
            b_mem[wr_slot][b_addr] <= AXIS_TDATA;
        A_data <= a_mem[a_ptr[rd_slot]][A_read_addr];
        B_data <= b_mem[rd_slot][B_read_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            full      <= '0;
            k_slot[0] <= '0;
            k_slot[1] <= '0;
            a_ptr     <= '0;
            last_a    <= 1'b0;
            wr_slot   <= 1'b0;
            rd_slot   <= 1'b0;
            a_addr    <= '0;
            b_addr    <= '0;
`ifdef INPUT_MEMS_KCHECK_EN
            k_err     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!k_ok) begin
`ifdef INPUT_MEMS_KCHECK_EN
                            k_err <= 1'b1;
`endif
                        end else begin
                            k_slot[wr_slot] <= user_k;
                            if (user_new_a) begin
                                a_ptr[wr_slot] <= wr_slot;
                                last_a         <= wr_slot;
                                a_addr         <= A_ADDR_BITS'(1);
                                state          <= LOAD_A;
                            end else begin
                                a_ptr[wr_slot] <= last_a;
                                b_addr         <= B_ADDR_BITS'(1);
                                state          <= LOAD_B;
                            end
                        end
                    end
                end
                LOAD_A: begin
                    if (accept) begin
                        if (a_last) begin
                            a_addr <= '0;
                            b_addr <= '0;
                            state  <= LOAD_B;
                        end else begin
                            a_addr <= a_addr + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        if (b_last) begin
                            full[wr_slot] <= 1'b1;
                            wr_slot       <= ~wr_slot;
                            a_addr        <= '0;
                            b_addr        <= '0;
                            state         <= IDLE;
                        end else begin
                            b_addr <= b_addr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A slot being completed is never the full read slot, so this and
            // the completion above always touch different bits of full.
            if (compute_finished && full[rd_slot]) begin
                full[rd_slot] <= 1'b0;
                rd_slot       <= ~rd_slot;
            end
        end
    end

endmodule
